// File: rtl/ex_mem_wb_forward.sv
// EX/MEM and MEM/WB pipeline registers with operand-forwarding selects,
// load-use stall detection and a saturating stall-cycle counter.
module ex_mem_wb_forward (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] EX_ALUresult,
  input  logic [31:0] EX_ReadData2,
  input  logic [4:0]  EX_RegDest,
  input  logic        EX_RegWrite,
  input  logic        EX_MemRead,
  input  logic        EX_MemWrite,
  input  logic        EX_MemtoReg,
  input  logic [4:0]  IDtoEX_Rs,
  input  logic [4:0]  IDtoEX_Rt,
  input  logic        IDtoEX_MemRead,
  input  logic [4:0]  IFtoID_Rs,
  input  logic [4:0]  IFtoID_Rt,
  input  logic [31:0] MEM_ReadData,
  output logic [31:0] EXtoMEM_ALUresult,
  output logic [31:0] EXtoMEM_WriteData,
  output logic [4:0]  EXtoMEM_RegDest,
  output logic        EXtoMEM_RegWrite,
  output logic        EXtoMEM_MemRead,
  output logic        EXtoMEM_MemWrite,
  output logic [31:0] WB_ALUresult,
  output logic [4:0]  WB_RegDest,
  output logic        WB_RegWrite,
  output logic [1:0]  ForwardA,
  output logic [1:0]  ForwardB,
  output logic        Stall,
  output logic [15:0] StallCount
);

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  reg_dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [4:0]  reg_dest;
    logic        reg_write;
  } mem_wb_t;

  ex_mem_t     ex_mem_d, ex_mem_q;
  mem_wb_t     mem_wb_d, mem_wb_q;
  logic [15:0] stall_count_d, stall_count_q;
  logic        stall;

  // Register 0 is hard-wired to zero, so a write to it is never a real producer.
  function automatic fwd_sel_e fwd_select(
    input logic [4:0] src,
    input logic       mem_rw,
    input logic [4:0] mem_rd,
    input logic       wb_rw,
    input logic [4:0] wb_rd
  );
    if (mem_rw && (mem_rd != 5'd0) && (mem_rd == src)) return FWD_MEM;
    else if (wb_rw && (wb_rd != 5'd0) && (wb_rd == src)) return FWD_WB;
    else return FWD_REG;
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ex_mem_d            = ex_mem_q;
    ex_mem_d.alu_result = EX_ALUresult;
    ex_mem_d.write_data = EX_ReadData2;
    ex_mem_d.reg_dest   = EX_RegDest;
    ex_mem_d.reg_write  = EX_RegWrite;
    ex_mem_d.mem_read   = EX_MemRead;
    ex_mem_d.mem_write  = EX_MemWrite;
    ex_mem_d.mem_to_reg = EX_MemtoReg;

    mem_wb_d            = mem_wb_q;
    mem_wb_d.alu_result = ex_mem_q.mem_to_reg ? MEM_ReadData : ex_mem_q.alu_result;
    mem_wb_d.reg_dest   = ex_mem_q.reg_dest;
    mem_wb_d.reg_write  = ex_mem_q.reg_write;

    stall = IDtoEX_MemRead && (IDtoEX_Rt != 5'd0) &&
            ((IDtoEX_Rt == IFtoID_Rs) || (IDtoEX_Rt == IFtoID_Rt));

    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem_q      <= '0;
      mem_wb_q      <= '0;
      stall_count_q <= '0;
    end else begin
      ex_mem_q      <= ex_mem_d;
      mem_wb_q      <= mem_wb_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign EXtoMEM_ALUresult = ex_mem_q.alu_result;
  assign EXtoMEM_WriteData = ex_mem_q.write_data;
  assign EXtoMEM_RegDest   = ex_mem_q.reg_dest;
  assign EXtoMEM_RegWrite  = ex_mem_q.reg_write;
  assign EXtoMEM_MemRead   = ex_mem_q.mem_read;
  assign EXtoMEM_MemWrite  = ex_mem_q.mem_write;

  assign WB_ALUresult = mem_wb_q.alu_result;
  assign WB_RegDest   = mem_wb_q.reg_dest;
  assign WB_RegWrite  = mem_wb_q.reg_write;

  // A load in EX/MEM still forwards its address; the stall has already bubbled any dependent use.
  assign ForwardA   = fwd_select(IDtoEX_Rs, ex_mem_q.reg_write, ex_mem_q.reg_dest,
                                 mem_wb_q.reg_write, mem_wb_q.reg_dest);
  assign ForwardB   = fwd_select(IDtoEX_Rt, ex_mem_q.reg_write, ex_mem_q.reg_dest,
                                 mem_wb_q.reg_write, mem_wb_q.reg_dest);
  assign Stall      = stall;
  assign StallCount = stall_count_q;

endmodule
